// File: rtl/somador_pkg.sv
// somador_pkg: controller state encoding and width helpers shared by the
// group-sum controller and its datapath.
package somador_pkg;
  typedef enum logic [2:0] {IDLE, CLR, RD, ACC, WR, DONE} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  // Wide enough that a running sum over every word of a run never wraps.
  function automatic int sum_w(input int data_w, input int words);
    return data_w + clog2(words);
  endfunction
endpackage

// File: rtl/group_accum_dp.sv
// group_accum_dp: group accumulator with write-back saturate/truncate and a
// sticky overflow flag; updates on the falling edge like the controller.
module group_accum_dp import somador_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int SUM_W  = 13,
  parameter int SAT    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic              wr_i,
  input  logic              ovf_clr_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic              ovf_o
);
  logic [SUM_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d, big;
  always_comb begin
    big     = acc_q > SUM_W'({DATA_W{1'b1}});
    acc_d   = clr_i ? '0 : add_i ? acc_q + SUM_W'(rdata_i) : acc_q;
    ovf_d   = ovf_clr_i ? 1'b0 : ovf_q | (wr_i & big);
    wdata_o = !wr_i ? '0 : (big && SAT != 0) ? '1 : acc_q[DATA_W-1:0];
    ovf_o   = ovf_q;
  end
  always_ff @(negedge clk or negedge reset)
    if (!reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
endmodule

// File: rtl/group_accum_ctrl.sv
// group_accum_ctrl: sequences a single-port RAM, summing NUM_GROUPS groups of
// GROUP words and writing each result over the group's last word.
module group_accum_ctrl import somador_pkg::*; #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 5,
  parameter int GROUP      = 8,
  parameter int NUM_GROUPS = 4,
  parameter int RD_LAT     = 2,
  parameter int SAT        = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              ready,
  output logic              ovf,
  output logic [ADDR_W-1:0] address,
  output logic              rden,
  output logic              wren,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] wdata
);
  localparam int SUM_W = sum_w(DATA_W, GROUP * NUM_GROUPS);
  localparam int LW    = clog2(RD_LAT + 1);
  localparam int WW    = clog2(GROUP + 1);
  localparam int GW    = clog2(NUM_GROUPS + 1);
  state_e            state_q, state_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mode_q, mode_d;
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    wcnt_d  = wcnt_q;
    gcnt_d  = gcnt_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CLR;
        mode_d  = mode;
        gcnt_d  = '0;
        addr_d  = '0;
      end
      CLR: begin
        wcnt_d  = '0;
        lat_d   = '0;
        state_d = RD;
      end
      RD: begin
        lat_d   = lat_q + 1'b1;
        state_d = lat_q == LW'(RD_LAT - 1) ? ACC : RD;
      end
      ACC: begin
        lat_d = '0;
        if (wcnt_q == WW'(GROUP - 1)) state_d = WR;
        else begin
          wcnt_d  = wcnt_q + 1'b1;
          addr_d  = addr_q + 1'b1;
          state_d = RD;
        end
      end
      WR:
        if (gcnt_q == GW'(NUM_GROUPS - 1)) state_d = DONE;
        else begin
          gcnt_d  = gcnt_q + 1'b1;
          addr_d  = addr_q + 1'b1;
          state_d = CLR;
        end
      DONE: begin
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy    = state_q != IDLE;
    ready   = state_q == DONE;
    rden    = state_q == RD || state_q == ACC;
    wren    = state_q == WR;
    address = addr_q;
  end
  // Falling-edge state so the rising-edge RAM always sees settled controls.
  always_ff @(negedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      lat_q   <= '0;
      wcnt_q  <= '0;
      gcnt_q  <= '0;
      addr_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      wcnt_q  <= wcnt_d;
      gcnt_q  <= gcnt_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
    end
  // Running-sum mode keeps the accumulator across groups after the first.
  group_accum_dp #(.DATA_W(DATA_W), .SUM_W(SUM_W), .SAT(SAT)) u_dp (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_q == CLR && !(mode_q && gcnt_q != '0)),
    .add_i    (state_q == ACC),
    .wr_i     (wren),
    .ovf_clr_i(state_q == IDLE && start),
    .rdata_i  (rdata),
    .wdata_o  (wdata),
    .ovf_o    (ovf)
  );
endmodule
